// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: instruction constants, default datapath width and the
// fetch-stage state encoding.
package wisc_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;

  // Major opcode field [15:11] that marks a HALT instruction.
  localparam logic [4:0]  OP_HALT   = 5'b00000;
  // Bubble encoding that decode treats as a no-op.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    StReq    = 2'd0,  // request outstanding at PC
    StHold   = 2'd1,  // word captured in skid buffer, waiting for stall to drop
    StDrain  = 2'd2,  // redirected; waiting out a stale request
    StHalted = 2'd3   // HALT reached IF/ID; fetch stopped
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between fetch (master) and memory (slave).
//   imem_rd   : read request, held until imem_done
//   imem_addr : fetch address, stable while imem_rd is high
//   imem_data : read data, valid only with imem_done
//   imem_done : one-cycle completion pulse
interface fetch_stage_if
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  imem_rd;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  imem_done;

  modport master (output imem_rd, imem_addr, input imem_data, imem_done);
  modport slave  (input imem_rd, imem_addr, output imem_data, imem_done);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : capture instr_in/seq_pc_in, mark valid
//   flush     : insert a NOP bubble (seq_PC kept), mark invalid; wins over load
//   instruc, seq_PC, valid : register contents presented to decode
module if_id_reg #(
  parameter int unsigned           DATA_WIDTH = wisc_pkg::DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = wisc_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [DATA_WIDTH-1:0] seq_pc_in,
  output logic [DATA_WIDTH-1:0] instruc,
  output logic [DATA_WIDTH-1:0] seq_PC,
  output logic                  valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruc <= NOP_INSTR;
      seq_PC  <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      instruc <= NOP_INSTR;
      valid   <= 1'b0;
    end else if (load) begin
      instruc <= instr_in;
      seq_PC  <= seq_pc_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: PC, instruction-memory request FSM, skid buffer and IF/ID
// register feeding decode.
//   clk, rst       : clock, asynchronous active-low reset
//   stall          : hold IF/ID and PC
//   redirect       : taken branch/jump, redirect_PC is the target (highest priority)
//   imem           : instruction-memory bus (master side)
//   instruc/seq_PC : IF/ID instruction and PC+2; if_valid marks a real instruction
//   halted         : fetch stopped on a HALT
//   err            : sticky misaligned-redirect / unexpected-done error
//   perf_wait_cyc  : memory-wait cycle counter, present only when FETCH_PERF_CNT_EN is defined
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = wisc_pkg::DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = wisc_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_PC,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] instruc,
  output logic [DATA_WIDTH-1:0] seq_PC,
  output logic                  if_valid,
  output logic                  halted,
  output logic                  err,
  output logic [15:0]           perf_wait_cyc
);
  import wisc_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  halted_q, halted_d;
  logic                  err_q, err_d;
  logic                  ifid_load, ifid_flush;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic [DATA_WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + DATA_WIDTH'(2);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drain_addr_d   = drain_addr_q;
    skid_d         = skid_q;
    halted_d       = halted_q;
    err_d          = err_q;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_instr     = imem.imem_data;
    imem.imem_rd   = 1'b0;
    imem.imem_addr = pc_q;

    unique case (state_q)
      StReq:    imem.imem_rd = 1'b1;
      StDrain: begin
        // The stale request keeps its original address until it completes.
        imem.imem_rd   = 1'b1;
        imem.imem_addr = drain_addr_q;
      end
      StHold:   ;
      StHalted: ;
    endcase

    // No request is outstanding in these states, so a done pulse is a protocol error.
    if (imem.imem_done && (state_q == StHold || state_q == StHalted)) begin
      err_d = 1'b1;
    end

    if (redirect) begin
      ifid_flush = 1'b1;
      pc_d       = {redirect_PC[DATA_WIDTH-1:1], 1'b0};
      halted_d   = 1'b0;
      if (redirect_PC[0]) err_d = 1'b1;
      unique case (state_q)
        StReq: begin
          if (!imem.imem_done) begin
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end
        end
        StDrain:  if (imem.imem_done) state_d = StReq;
        StHold:   state_d = StReq;
        StHalted: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem.imem_done) begin
            if (stall) begin
              skid_d  = imem.imem_data;
              state_d = StHold;
            end else begin
              ifid_load = 1'b1;
              pc_d      = pc_inc;
            end
          end else if (!stall) begin
            ifid_flush = 1'b1;
          end
        end
        StHold: begin
          if (!stall) begin
            ifid_load  = 1'b1;
            ifid_instr = skid_q;
            pc_d       = pc_inc;
            state_d    = StReq;
          end
        end
        StDrain: begin
          if (imem.imem_done) state_d = StReq;
          if (!stall) ifid_flush = 1'b1;
        end
        StHalted: begin
          if (!stall) ifid_flush = 1'b1;
        end
      endcase
      if (ifid_load && ifid_instr[DATA_WIDTH-1 -: 5] == OP_HALT) begin
        halted_d = 1'b1;
        state_d  = StHalted;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      skid_q       <= NOP_INSTR;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_q       <= skid_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
    end
  end

  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .instr_in  (ifid_instr),
    .seq_pc_in (pc_inc),
    .instruc   (instruc),
    .seq_PC    (seq_PC),
    .valid     (if_valid)
  );

  assign halted = halted_q;
  assign err    = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (imem.imem_rd && !imem.imem_done && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_wait_cyc = perf_q;
`else
  assign perf_wait_cyc = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_PC;
  logic [15:0] instruc;
  logic [15:0] seq_PC;
  logic        if_valid;
  logic        halted;
  logic        err;
  logic [15:0] perf_wait_cyc;

  int vectors     = 0;
  int miscompares = 0;

  fetch_stage_if #(.DATA_WIDTH(16)) imem ();

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_PC   (redirect_PC),
    .imem          (imem),
    .instruc       (instruc),
    .seq_PC        (seq_PC),
    .if_valid      (if_valid),
    .halted        (halted),
    .err           (err),
    .perf_wait_cyc (perf_wait_cyc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag, input logic [15:0] exp_en);
`ifdef FETCH_PERF_CNT_EN
    chk(tag, perf_wait_cyc, exp_en);
`else
    chk(tag, perf_wait_cyc, 16'h0000);
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_PC = 16'h0000;
    imem.imem_data = 16'h0000; imem.imem_done = 1'b0;
    #2 rst = 1'b0;
    #1;
    // Reset state
    chk("rst_instruc", instruc, 16'h0800);
    chk("rst_seq", seq_PC, 16'h0000);
    chk("rst_valid", {15'd0, if_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_perf", perf_wait_cyc, 16'h0000);
    chk("rst_rd", {15'd0, imem.imem_rd}, 16'd1);
    chk("rst_addr", imem.imem_addr, 16'h0000);
    #9 rst = 1'b1;

    // 1-cycle memory
    imem.imem_done = 1'b1; imem.imem_data = 16'hC123;
    tick();
    chk("f1_instruc", instruc, 16'hC123);
    chk("f1_seq", seq_PC, 16'h0002);
    chk("f1_valid", {15'd0, if_valid}, 16'd1);
    chk("f1_addr", imem.imem_addr, 16'h0002);
    imem.imem_data = 16'h4567;
    tick();
    chk("f2_instruc", instruc, 16'h4567);
    chk("f2_seq", seq_PC, 16'h0004);
    chk("f2_addr", imem.imem_addr, 16'h0004);

    // Redirect to 0x0010 with a request outstanding: drain old address
    imem.imem_done = 1'b0; redirect = 1'b1; redirect_PC = 16'h0010;
    tick();
    redirect = 1'b0;
    chk("d1_instruc", instruc, 16'h0800);
    chk("d1_valid", {15'd0, if_valid}, 16'd0);
    chk("d1_addr_old", imem.imem_addr, 16'h0004);
    chk("d1_rd", {15'd0, imem.imem_rd}, 16'd1);
    imem.imem_done = 1'b1; imem.imem_data = 16'h1234;
    tick();
    imem.imem_done = 1'b0;
    chk("d1_discard", instruc, 16'h0800);
    chk("d1_addr_new", imem.imem_addr, 16'h0010);

    // 3-cycle latency at 0x0010
    tick();
    chk("w1_instruc", instruc, 16'h0800);
    chk("w1_valid", {15'd0, if_valid}, 16'd0);
    chk("w1_seq", seq_PC, 16'h0004);
    chk("w1_addr", imem.imem_addr, 16'h0010);
    tick();
    chk("w2_instruc", instruc, 16'h0800);
    chk("w2_addr", imem.imem_addr, 16'h0010);
    imem.imem_done = 1'b1; imem.imem_data = 16'h5A5A;
    tick();
    chk("w3_instruc", instruc, 16'h5A5A);
    chk("w3_seq", seq_PC, 16'h0012);
    chk("w3_valid", {15'd0, if_valid}, 16'd1);
    chk("w3_addr", imem.imem_addr, 16'h0012);
    chk_perf("w3_perf", 16'd3);

    // Done under stall: skid buffer, HOLD for two cycles
    imem.imem_data = 16'h6B6B; stall = 1'b1;
    tick();
    imem.imem_done = 1'b0;
    chk("h1_instruc", instruc, 16'h5A5A);
    chk("h1_rd", {15'd0, imem.imem_rd}, 16'd0);
    tick();
    chk("h2_instruc", instruc, 16'h5A5A);
    chk("h2_seq", seq_PC, 16'h0012);
    chk("h2_rd", {15'd0, imem.imem_rd}, 16'd0);
    stall = 1'b0;
    tick();
    chk("h3_instruc", instruc, 16'h6B6B);
    chk("h3_seq", seq_PC, 16'h0014);
    chk("h3_valid", {15'd0, if_valid}, 16'd1);
    chk("h3_addr", imem.imem_addr, 16'h0014);
    chk("h3_rd", {15'd0, imem.imem_rd}, 16'd1);

    // Redirect to 0x0020 coinciding with done: data dropped, straight to REQ
    imem.imem_done = 1'b1; imem.imem_data = 16'h7777;
    redirect = 1'b1; redirect_PC = 16'h0020;
    tick();
    redirect = 1'b0; imem.imem_done = 1'b0;
    chk("r0_instruc", instruc, 16'h0800);
    chk("r0_addr", imem.imem_addr, 16'h0020);
    tick();
    // Redirect to 0x0100 mid-request at 0x0020
    redirect = 1'b1; redirect_PC = 16'h0100;
    tick();
    redirect = 1'b0;
    chk("r1_instruc", instruc, 16'h0800);
    chk("r1_valid", {15'd0, if_valid}, 16'd0);
    chk("r1_addr_old", imem.imem_addr, 16'h0020);
    imem.imem_done = 1'b1; imem.imem_data = 16'h1111;
    tick();
    imem.imem_done = 1'b0;
    chk("r1_discard", instruc, 16'h0800);
    chk("r1_addr_new", imem.imem_addr, 16'h0100);
    chk("r1_err", {15'd0, err}, 16'd0);
    // Misaligned redirect target
    redirect = 1'b1; redirect_PC = 16'h0101;
    tick();
    redirect = 1'b0;
    chk("r2_err", {15'd0, err}, 16'd1);
    imem.imem_done = 1'b1; imem.imem_data = 16'h2222;
    tick();
    chk("r2_addr", imem.imem_addr, 16'h0100);
    chk("r2_rd", {15'd0, imem.imem_rd}, 16'd1);

    // HALT at 0x0030
    redirect = 1'b1; redirect_PC = 16'h0030;
    tick();
    redirect = 1'b0;
    chk("x0_addr", imem.imem_addr, 16'h0030);
    imem.imem_data = 16'h0000;
    tick();
    imem.imem_done = 1'b0;
    chk("x1_instruc", instruc, 16'h0000);
    chk("x1_seq", seq_PC, 16'h0032);
    chk("x1_halted", {15'd0, halted}, 16'd1);
    chk("x1_rd", {15'd0, imem.imem_rd}, 16'd0);
    tick();
    chk("x2_instruc", instruc, 16'h0800);
    chk("x2_valid", {15'd0, if_valid}, 16'd0);
    chk("x2_rd", {15'd0, imem.imem_rd}, 16'd0);
    chk("x2_halted", {15'd0, halted}, 16'd1);
    redirect = 1'b1; redirect_PC = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("x3_halted", {15'd0, halted}, 16'd0);
    chk("x3_addr", imem.imem_addr, 16'h0040);
    chk("x3_rd", {15'd0, imem.imem_rd}, 16'd1);
    imem.imem_done = 1'b1; imem.imem_data = 16'h3333;
    tick();
    chk("x4_instruc", instruc, 16'h3333);
    chk("x4_seq", seq_PC, 16'h0042);

    // PC wrap at 0xFFFE
    redirect = 1'b1; redirect_PC = 16'hFFFE; imem.imem_data = 16'h9999;
    tick();
    redirect = 1'b0;
    chk("p0_addr", imem.imem_addr, 16'hFFFE);
    imem.imem_data = 16'h4444;
    tick();
    imem.imem_done = 1'b0;
    chk("p1_instruc", instruc, 16'h4444);
    chk("p1_seq", seq_PC, 16'h0000);
    chk("p1_addr", imem.imem_addr, 16'h0000);
    chk("p1_err", {15'd0, err}, 16'd1);
    chk_perf("p1_perf", 16'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
